// File: rtl/bp_counter_ctrl_if.sv
// Cache-side bus between bp_counter_ctrl and bp_cache.
// master = controller, slave = cache.
interface bp_counter_ctrl_if #(
  parameter int AWIDTH = 32,
  parameter int CWIDTH = 2
);
  logic [AWIDTH-1:0] ra0;
  logic [AWIDTH-1:0] ra1;
  logic [AWIDTH-1:0] wa;
  logic [CWIDTH-1:0] din;
  logic              we;
  logic [CWIDTH-1:0] dout0;
  logic [CWIDTH-1:0] dout1;
  logic              hit0;
  logic              hit1;

  modport master (
    output ra0, ra1, wa, din, we,
    input  dout0, dout1, hit0, hit1
  );

  modport slave (
    input  ra0, ra1, wa, din, we,
    output dout0, dout1, hit0, hit1
  );
endinterface

// File: rtl/bp_counter_ctrl.sv
// Saturating-counter predictor controller in front of bp_cache:
// lookup, two-stage train with forwarding, branch statistics.
module bp_counter_ctrl #(
  parameter int AWIDTH = 32,
  parameter int CWIDTH = 2,
  parameter int CNTW   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] guess_pc,
  input  logic              is_br_guess,
  output logic              guess,
  input  logic [AWIDTH-1:0] check_pc,
  input  logic              is_br_check,
  input  logic              br_taken_check,
  input  logic              pred_check,
  input  logic              stat_clear,
  output logic [CNTW-1:0]   num_br,
  output logic [CNTW-1:0]   num_mispred,
  bp_counter_ctrl_if.master cache
);

  typedef logic [CWIDTH-1:0] cnt_t;

  localparam cnt_t WNT  = cnt_t'((1 << (CWIDTH - 1)) - 1);
  localparam cnt_t CMAX = '1;
  localparam cnt_t CMIN = '0;

  logic [AWIDTH-1:0] upd_addr;
  cnt_t              upd_cnt;
  logic              upd_valid;

  cnt_t g;
  cnt_t old;
  cnt_t nxt;

  // A miss behaves as weakly-not-taken.
  function automatic cnt_t eff(input cnt_t c, input logic hit);
    return hit ? c : WNT;
  endfunction

  always_comb begin
    g = eff(cache.dout0, cache.hit0);
    if (upd_valid && upd_addr == guess_pc)
      g = upd_cnt;
    guess = is_br_guess & g[CWIDTH-1];
  end

  always_comb begin
    old = eff(cache.dout1, cache.hit1);
    if (upd_valid && upd_addr == check_pc)
      old = upd_cnt;
    nxt = old;
    if (br_taken_check) begin
      if (old != CMAX)
        nxt = old + cnt_t'(1);
    end else begin
      if (old != CMIN)
        nxt = old - cnt_t'(1);
    end
  end

  assign cache.ra0 = guess_pc;
  assign cache.ra1 = check_pc;
  assign cache.wa  = upd_addr;
  assign cache.din = upd_cnt;
  assign cache.we  = upd_valid;

  // The pending update register doubles as the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid <= 1'b0;
      upd_addr  <= '0;
      upd_cnt   <= '0;
    end else begin
      upd_valid <= is_br_check;
      if (is_br_check) begin
        upd_addr <= check_pc;
        upd_cnt  <= nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_br      <= '0;
      num_mispred <= '0;
    end else if (stat_clear) begin
      num_br      <= '0;
      num_mispred <= '0;
    end else if (is_br_check) begin
      if (num_br != '1)
        num_br <= num_br + CNTW'(1);
      if (pred_check != br_taken_check && num_mispred != '1)
        num_mispred <= num_mispred + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_bp_counter_ctrl.sv
// Scoreboard bench for bp_counter_ctrl with a 128-line
// direct-mapped cache model on the cache bus.
module tb_bp_counter_ctrl;

  localparam int AW = 32;
  localparam int CW = 2;
  localparam int CN = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] guess_pc = '0;
  logic          is_br_guess = 1'b0;
  logic          guess;
  logic [AW-1:0] check_pc = '0;
  logic          is_br_check = 1'b0;
  logic          br_taken_check = 1'b0;
  logic          pred_check = 1'b0;
  logic          stat_clear = 1'b0;
  logic [CN-1:0] num_br;
  logic [CN-1:0] num_mispred;

  bp_counter_ctrl_if #(.AWIDTH(AW), .CWIDTH(CW)) cbus ();

  bp_counter_ctrl #(.AWIDTH(AW), .CWIDTH(CW), .CNTW(CN)) dut (
    .clk(clk),
    .reset(reset),
    .guess_pc(guess_pc),
    .is_br_guess(is_br_guess),
    .guess(guess),
    .check_pc(check_pc),
    .is_br_check(is_br_check),
    .br_taken_check(br_taken_check),
    .pred_check(pred_check),
    .stat_clear(stat_clear),
    .num_br(num_br),
    .num_mispred(num_mispred),
    .cache(cbus.master)
  );

  always #5 clk = ~clk;

  // Cache: index pc[6:0], tag pc[31:7]
  logic [24:0] ctag [128];
  logic [1:0]  cval [128];
  logic        cvld [128];
  logic        cinit = 1'b1;
  logic [6:0]  i0, i1;

  always @(posedge clk) begin
    if (cinit) begin
      for (int i = 0; i < 128; i++) cvld[i] <= 1'b0;
    end else if (cbus.we) begin
      cvld[cbus.wa[6:0]] <= 1'b1;
      ctag[cbus.wa[6:0]] <= cbus.wa[31:7];
      cval[cbus.wa[6:0]] <= cbus.din;
    end
  end

  always_comb begin
    i0 = cbus.ra0[6:0];
    i1 = cbus.ra1[6:0];
    cbus.hit0  = cvld[i0] && ctag[i0] == cbus.ra0[31:7];
    cbus.hit1  = cvld[i1] && ctag[i1] == cbus.ra1[31:7];
    cbus.dout0 = cval[i0];
    cbus.dout1 = cval[i1];
  end

  // Reference: predictor state after every issued branch
  logic [24:0] mtag [128];
  bit [1:0]    mval [128];
  bit          mvld [128];
  int          mbr = 0;
  int          mmis = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  d;
  } wr_t;

  wr_t         wq [$];
  bit          gq [$];
  logic [63:0] sq [$];
  bit          gprobe = 1'b0;
  bit          sprobe = 1'b0;
  int          errors = 0;
  int          checks = 0;

  bit [31:0] pool [8] = '{32'h11, 32'h100, 32'h23, 32'h1C5,
                          32'h67, 32'h389, 32'h2B, 32'h5E};

  function automatic bit [1:0] mget(input logic [31:0] pc);
    int i;
    i = int'(pc[6:0]);
    if (mvld[i] && mtag[i] == pc[31:7]) return mval[i];
    return 2'd1;
  endfunction

  task automatic mset(input logic [31:0] pc, input bit [1:0] v);
    int i;
    i = int'(pc[6:0]);
    mvld[i] = 1'b1;
    mtag[i] = pc[31:7];
    mval[i] = v;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] gpc, input bit gbr,
                     input bit gp, input logic [31:0] cpc,
                     input bit cbr, input bit tk, input bit pr,
                     input bit clr, input bit sp, input bit ap);
    bit [1:0] o, n, gv;
    @(posedge clk);
    #1;
    guess_pc = gpc;
    is_br_guess = gbr;
    check_pc = cpc;
    is_br_check = cbr;
    br_taken_check = tk;
    pred_check = pr;
    stat_clear = clr;
    gprobe = gp;
    sprobe = sp;
    gv = mget(gpc);
    if (gp) gq.push_back(gbr & gv[1]);
    if (sp) sq.push_back({32'(mbr), 32'(mmis)});
    if (cbr) begin
      o = mget(cpc);
      if (tk) n = (o == 2'd3) ? o : o + 2'd1;
      else    n = (o == 2'd0) ? o : o - 2'd1;
      wq.push_back('{a: cpc, d: n});
      if (ap) mset(cpc, n);
    end
    if (clr) begin
      mbr = 0;
      mmis = 0;
    end else if (cbr) begin
      mbr++;
      if (pr != tk) mmis++;
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk_br(input logic [31:0] pc, input bit tk);
    cyc(0, 0, 0, pc, 1, tk, tk, 0, 0, 1);
  endtask

  task automatic probe_g(input logic [31:0] pc);
    cyc(pc, 1, 1, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mvld[i] = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (cbus.we) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write_unexpected: got wa=%0h din=%0h expected none",
                     cbus.wa, cbus.din);
          end else begin
            wr_t w;
            w = wq.pop_front();
            chk("write", {cbus.wa, cbus.din}, {w.a, w.d});
          end
        end
        if (gprobe && gq.size() != 0)
          chk("guess", guess, gq.pop_front());
        if (sprobe && sq.size() != 0)
          chk("stats", {num_br, num_mispred}, sq.pop_front());
      end
    join_none

    // T1: reset
    repeat (10) @(posedge clk);
    #1;
    chk("rst_we", cbus.we, 0);
    chk("rst_wa", cbus.wa, 0);
    chk("rst_din", cbus.din, 0);
    chk("rst_num_br", num_br, 0);
    chk("rst_num_mispred", num_mispred, 0);
    reset = 1'b0;
    cinit = 1'b0;
    probe_g(32'h0);
    #1;
    chk("t1_hit0", cbus.hit0, 0);
    chk("t1_guess", guess, 0);

    // T2: first training, then predict
    chk_br(32'h11, 1);
    probe_g(32'h11);
    idle();

    // T3: saturate up then down
    repeat (4) chk_br(32'h11, 1);
    repeat (4) chk_br(32'h11, 0);
    idle();
    probe_g(32'h11);

    // T4: tag conflict evicts
    repeat (3) chk_br(32'h11, 1);
    idle();
    chk_br(32'h11000011, 1);
    idle();
    probe_g(32'h11);
    chk("t4_guess_miss", guess, 0);

    // T5: guess forwarded from pending update
    chk_br(32'h100, 1);
    cyc(32'h100, 1, 1, 32'h100, 1, 0, 1, 0, 0, 1);
    idle();

    // T6: statistics, clear priority, reset mid-update
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 32'h23, 1, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 32'h23, 1, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 32'h67, 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 32'h2B, 1, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 32'h5E, 1, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("t6_num_br", num_br, 5);
    chk("t6_num_mispred", num_mispred, 2);
    cyc(0, 0, 0, 32'h40, 1, 1, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("t6_clr_num_br", num_br, 0);
    chk("t6_clr_num_mispred", num_mispred, 0);
    cyc(0, 0, 0, 32'h2A0, 1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    is_br_check = 1'b0;
    void'(wq.pop_back());
    mbr = 0;
    mmis = 0;
    #1;
    chk("t6_we_async_drop", cbus.we, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(32'h2A0, 1, 1, 0, 0, 0, 0, 0, 1, 1);
    chk("t6_no_write_landed", guess, 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cyc(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), 1,
          pool[$urandom_range(0, 7)], $urandom_range(0, 9) < 6,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 29) == 0, 1, 1);
    end
    repeat (3) idle();
    @(posedge clk);
    #1;
    chk("wq_drained", 64'(wq.size()), 0);
    chk("gq_drained", 64'(gq.size()), 0);
    chk("sq_drained", 64'(sq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
